// File: rtl/serial_byte_loader.sv
// Assembles an LSB-first serial frame (start strobe, DATA_W bits, optional even parity)
// into a byte and emits a one-cycle load strobe for the downstream data register.
module serial_byte_loader #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              bit_valid_i,
    input  logic              bit_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              load_o,
    output logic [DATA_W-1:0] data_o,
    output logic              parity_err_o,
    output logic [7:0]        frame_cnt_o
);

    localparam int unsigned BCNT_W = $clog2(DATA_W + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_sr, w_sr_nxt;
    logic [BCNT_W-1:0]   r_bcnt, w_bcnt_nxt;
    logic [DATA_W-1:0]   r_data, w_data_nxt;
    logic [7:0]          r_cnt, w_cnt_nxt;
    logic                r_load, w_load_nxt;
    logic                r_perr, w_perr_nxt;
    logic                r_busy, w_busy_nxt;
    logic [DATA_W-1:0]   w_shifted;

    assign w_shifted = {bit_i, r_sr[DATA_W-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_bcnt  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_load  <= 1'b0;
            r_perr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_data  <= w_data_nxt;
            r_cnt   <= w_cnt_nxt;
            r_load  <= w_load_nxt;
            r_perr  <= w_perr_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_bcnt_nxt  = r_bcnt;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_cnt;
        w_load_nxt  = 1'b0;
        w_perr_nxt  = 1'b0;

        if (abort_i) begin
            w_state_nxt = IDLE;
            w_bcnt_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        w_sr_nxt    = '0;
                        w_bcnt_nxt  = '0;
                        w_state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_valid_i) begin
                        w_sr_nxt   = w_shifted;
                        w_bcnt_nxt = r_bcnt + 1'b1;
                        if (r_bcnt == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                w_state_nxt = PARITY;
                            end else begin
                                // Final data bit completes the frame; load the word including it.
                                w_data_nxt  = w_shifted;
                                w_load_nxt  = 1'b1;
                                w_cnt_nxt   = r_cnt + 8'd1;
                                w_state_nxt = IDLE;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (bit_valid_i) begin
                        w_state_nxt = IDLE;
                        if ((^r_sr ^ bit_i) == 1'b0) begin
                            w_data_nxt = r_sr;
                            w_load_nxt = 1'b1;
                            w_cnt_nxt  = r_cnt + 8'd1;
                        end else begin
                            w_perr_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_bcnt_nxt  = '0;
                end
            endcase
        end

        // Registered busy follows the next state so it changes on the same edge as the state.
        w_busy_nxt = (w_state_nxt == SHIFT) || (w_state_nxt == PARITY);
    end

    assign busy_o       = r_busy;
    assign load_o       = r_load;
    assign data_o       = r_data;
    assign parity_err_o = r_perr;
    assign frame_cnt_o  = r_cnt;

endmodule

// File: tb/tb_serial_byte_loader.sv
// Directed bench for serial_byte_loader: parity and no-parity instances share the stimulus.
module tb_serial_byte_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       abort = 1'b0;

    logic       busy, load, perr;
    logic [7:0] data, cnt;
    logic       np_busy, np_load, np_perr;
    logic [7:0] np_data, np_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned load_seen = 0;
    int unsigned perr_seen = 0;

    always #5 clk = ~clk;

    serial_byte_loader #(.DATA_W(8), .PARITY_EN(1)) u_dut (
        .clk(clk), .reset(reset), .start_i(start), .bit_valid_i(bit_valid),
        .bit_i(bit_in), .abort_i(abort), .busy_o(busy), .load_o(load),
        .data_o(data), .parity_err_o(perr), .frame_cnt_o(cnt)
    );

    serial_byte_loader #(.DATA_W(8), .PARITY_EN(0)) u_np (
        .clk(clk), .reset(reset), .start_i(start), .bit_valid_i(bit_valid),
        .bit_i(bit_in), .abort_i(abort), .busy_o(np_busy), .load_o(np_load),
        .data_o(np_data), .parity_err_o(np_perr), .frame_cnt_o(np_cnt)
    );

    always @(negedge clk) begin
        if (load) load_seen++;
        if (perr) perr_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        step();
        bit_valid = 1'b0;
    endtask

    task automatic start_frame();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] d, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
            if (gaps) repeat (i % 4) step();
        end
    endtask

    task automatic clear_seen();
        load_seen = 0;
        perr_seen = 0;
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_load", load, 0);
        check_eq("rst_perr", perr, 0);
        check_eq("rst_data", data, 8'h00);
        check_eq("rst_cnt",  cnt, 8'h00);

        // Good frame 0xA5, parity 0
        clear_seen();
        start_frame();
        check_eq("a5_busy_rise", busy, 1);
        send_data(8'hA5, 1'b0);
        check_eq("a5_busy_wait_par", busy, 1);
        send_bit(1'b0);
        check_eq("a5_load", load, 1);
        check_eq("a5_data", data, 8'hA5);
        check_eq("a5_cnt",  cnt, 8'd1);
        check_eq("a5_busy_fall", busy, 0);
        step();
        check_eq("a5_load_fall", load, 0);
        check_eq("a5_load_pulses", load_seen, 1);
        check_eq("a5_perr_pulses", perr_seen, 0);

        // Parity error on 0x3C with parity 1
        clear_seen();
        start_frame();
        send_data(8'h3C, 1'b0);
        send_bit(1'b1);
        check_eq("3c_perr", perr, 1);
        check_eq("3c_load", load, 0);
        check_eq("3c_data", data, 8'hA5);
        check_eq("3c_cnt",  cnt, 8'd1);
        step();
        check_eq("3c_perr_fall", perr, 0);
        check_eq("3c_perr_pulses", perr_seen, 1);
        check_eq("3c_load_pulses", load_seen, 0);

        // 0x81 with gaps and a mid-frame start
        clear_seen();
        start_frame();
        for (int i = 0; i < 8; i++) begin
            send_bit(i == 0 || i == 7);
            repeat (i % 4) step();
            if (i == 3) start_frame();
        end
        check_eq("81_busy_mid", busy, 1);
        send_bit(1'b0);
        check_eq("81_load", load, 1);
        check_eq("81_data", data, 8'h81);
        check_eq("81_cnt",  cnt, 8'd2);
        step();
        check_eq("81_load_pulses", load_seen, 1);

        // Abort after 4 bits
        clear_seen();
        start_frame();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("ab4_busy", busy, 0);
        // Abort coinciding with the parity bit
        start_frame();
        send_data(8'h0F, 1'b0);
        abort = 1'b1;
        send_bit(1'b0);
        abort = 1'b0;
        check_eq("abp_busy", busy, 0);
        check_eq("abp_load", load, 0);
        step();
        check_eq("ab_load_pulses", load_seen, 0);
        check_eq("ab_perr_pulses", perr_seen, 0);
        check_eq("ab_data", data, 8'h81);
        check_eq("ab_cnt",  cnt, 8'd2);
        start_frame();
        send_data(8'h5A, 1'b0);
        send_bit(1'b0);
        check_eq("5a_load", load, 1);
        check_eq("5a_data", data, 8'h5A);
        check_eq("5a_cnt",  cnt, 8'd3);

        // Reset mid-frame
        start_frame();
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_data", data, 8'h00);
        check_eq("mrst_cnt",  cnt, 8'd0);
        check_eq("mrst_load", load, 0);

        // Back-to-back frames: start during the load cycle
        clear_seen();
        start_frame();
        send_data(8'h12, 1'b0);
        send_bit(1'b0);
        check_eq("b2b1_load", load, 1);
        check_eq("b2b1_data", data, 8'h12);
        start_frame();
        check_eq("b2b2_busy", busy, 1);
        send_data(8'h34, 1'b0);
        send_bit(1'b1);
        check_eq("b2b2_load", load, 1);
        check_eq("b2b2_data", data, 8'h34);
        check_eq("b2b_cnt",   cnt, 8'd2);
        step();
        check_eq("b2b_load_pulses", load_seen, 2);

        // Counter wrap: 253 more frames reach 255, one more wraps to 0
        for (int f = 0; f < 253; f++) begin
            start_frame();
            send_data(f[7:0], 1'b0);
            send_bit(^f[7:0]);
        end
        check_eq("wrap_255", cnt, 8'd255);
        start_frame();
        send_data(8'hC3, 1'b0);
        send_bit(1'b0);
        check_eq("wrap_0", cnt, 8'd0);
        check_eq("wrap_data", data, 8'hC3);

        // No-parity instance: 0xFF loads right after the 8th bit
        step();
        start_frame();
        send_data(8'hFF, 1'b0);
        check_eq("np_load", np_load, 1);
        check_eq("np_data", np_data, 8'hFF);
        check_eq("np_busy", np_busy, 0);
        check_eq("np_perr", np_perr, 0);
        check_eq("par_still_busy", busy, 1);
        send_bit(1'b0);
        check_eq("np_load_fall", np_load, 0);
        check_eq("ff_load", load, 1);
        check_eq("ff_data", data, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_byte_loader.md
# serial_byte_loader

Upstream stage for the 8-bit enabled data register. Assembles an LSB-first serial bit stream, framed by a start strobe and optionally checked with an even-parity bit, into a parallel byte. On a good frame it issues a single-cycle load strobe with the byte, which drive the register's enable and data inputs directly. Bad or aborted frames never produce a load, so the downstream register keeps its last good value.

## Interface
- DATA_W, 8, width of the assembled word and of `data_o`.
- PARITY_EN, 1: 1 means a parity bit follows the data bits and is checked (even parity); 0 means there is no parity bit.
- `clk`  in  1  the only clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset. Reset is synchronous and active-high; it is sampled on the rising edge of `clk`.
- `start_i`  in  1  begins a frame; honoured only in IDLE.
- `bit_valid_i`  in  1  qualifies `bit_i`; sampled only in SHIFT and PARITY.
- `bit_i`  in  1  serial data or parity bit.
- `abort_i`  in  1  drops the current frame; highest priority after `reset`.
- `busy_o`  out  1  high while the state is SHIFT or PARITY.
- `load_o`  out  1  one-cycle pulse on a good frame; drives the downstream `en_i`.
- `data_o`  out  DATA_W  the last good word; drives the downstream `d_in`; changes only when `load_o` rises.
- `parity_err_o`  out  1  one-cycle pulse on a parity mismatch.
- `frame_cnt_o`  out  8  count of good frames, mod 256.

## Operation
- States:
  - IDLE: wait for a frame.
  - SHIFT: collect DATA_W bits.
  - PARITY: collect the parity bit. This state is present only when PARITY_EN=1.
- Registers:
  - shift register `sr[DATA_W-1:0]`.
  - bit counter `bcnt`, sized to hold the value DATA_W.
  - `data_o`, `frame_cnt_o`, `load_o`, `parity_err_o`.
- IDLE:
  - If `start_i`=1 and `abort_i`=0, clear `bcnt` and `sr` and go to SHIFT.
  - `bit_valid_i` is ignored in IDLE.
- SHIFT, on each edge with `bit_valid_i`=1:
  - `sr <= {bit_i, sr[DATA_W-1:1]}`, so the first received bit lands in bit 0.
  - `bcnt <= bcnt+1`.
  - On the DATA_W-th bit, go to PARITY if PARITY_EN=1; otherwise complete the frame as good.
- SHIFT, with `bit_valid_i`=0: hold all state. Gaps of any length are legal.
- PARITY, on an edge with `bit_valid_i`=1:
  - The frame is good if XOR(`sr`, `bit_i`) = 0; otherwise it is bad.
  - Return to IDLE in either case.
- Good frame, all on the same edge:
  - `data_o <=` the final word (including the bit being shifted in when PARITY_EN=0).
  - `load_o <= 1`.
  - `frame_cnt_o <= frame_cnt_o+1`, wrapping 255 to 0.
  - Go to IDLE.
- Bad frame:
  - `parity_err_o <= 1`.
  - `data_o` and `frame_cnt_o` are unchanged.
- `load_o` and `parity_err_o` default to 0 on every other edge, so each is a single-cycle pulse.
- Priority: `reset` > `abort_i` > `start_i`/`bit_valid_i`.
- `abort_i`=1 in any state:
  - Next state is IDLE and `bcnt` is cleared.
  - No pulse is issued; `data_o` and `frame_cnt_o` are unchanged.
  - An `abort_i` coinciding with the final bit wins: there is no load.
- `start_i` while in SHIFT or PARITY is ignored.
- `start_i` during the cycle `load_o`=1 (the state is already IDLE) is accepted, which allows back-to-back frames.

## Timing
- Reset values:
  - state IDLE.
  - `busy_o`=0, `load_o`=0, `parity_err_o`=0.
  - `data_o`=0, `frame_cnt_o`=0.
  - `sr`=0, `bcnt`=0.
- Reset mid-frame: the frame is discarded and no pulse is issued.
- `busy_o` rises the edge after `start_i` is accepted. It falls on the same edge that `load_o`, `parity_err_o`, or the abort takes effect.
- Latency: `load_o` and the new `data_o` are visible in the cycle immediately after the edge that samples the final bit (the parity bit, or data bit DATA_W-1 when PARITY_EN=0). The downstream register captures the word one edge later.
- Minimum frame length:
  - PARITY_EN=1: 1 cycle for start + DATA_W+1 bit cycles.
  - PARITY_EN=0: 1 cycle for start + DATA_W bit cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Good frame: reset, then `start_i`, then bits 1,0,1,0,0,1,0,1 with parity 0, on consecutive cycles -> `load_o` is high for exactly 1 cycle, `data_o`=0xA5, `frame_cnt_o`=1, `parity_err_o` stays 0.
- Parity error: after the 0xA5 frame, send 0x3C (bits 0,0,1,1,1,1,0,0) with parity 1 -> `parity_err_o` pulses once, `load_o` stays 0, `data_o` remains 0xA5, `frame_cnt_o` remains 1.
- Gaps and ignored start: send 0x81 with 0–3 idle cycles between bits and a `start_i` pulse mid-frame -> a single load with `data_o`=0x81; the mid-frame start has no effect.
- Abort: assert `abort_i` after 4 bits, and in a separate frame together with the parity bit -> no pulses, `busy_o` drops the next edge, `data_o` and `frame_cnt_o` are unchanged. A fresh frame 0x5A then loads correctly.
- Reset mid-frame and back-to-back frames: assert `reset` after 3 bits -> all outputs return to 0. Then send frames with `start_i` coincident with `load_o` -> both load, and `frame_cnt_o` increments by 2.
- Counter wrap and PARITY_EN=0:
  - 256 good frames -> `frame_cnt_o` goes from 255 to 0.
  - With PARITY_EN=0, send 0xFF -> load issued after the 8th bit.
